cache_arbiter: RTL

Shares the single cacheline_adaptor line port between an instruction cache and a data cache once the unified cache is split.
- Arbitrates between the two requesters and latches the winner's address, direction and write line.
- Drives the adaptor until its response arrives, then routes the 256-bit read line and a one-cycle resp back to the winner only.
- Sits between the two cache pmem ports and the cacheline_adaptor line_i/line_o/address_i/read_i/write_i/resp_o interface.

---
 rtl/cache_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Two-way arbiter that shares one cacheline_adaptor port between the I-cache and the D-cache.
// The winner's request is latched for the whole burst, and the adaptor's response is routed back to that winner only.
module cache_arbiter #(
  parameter bit RR_EN  = 1'b1,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            state_reg;
  logic              last_grant_d_reg;
  logic [LINE_W-1:0] i_rdata_reg;
  logic [LINE_W-1:0] d_rdata_reg;

  logic req_i;
  logic req_d;
  logic grant_d;
  logic i_done;
  logic d_done;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  // On a tie D wins with fixed priority, or under round-robin when I had the last grant
  assign grant_d = req_d & (~req_i | ~RR_EN | ~last_grant_d_reg);

  assign i_done  = (state_reg == SERVE_I) & mem_resp;
  assign d_done  = (state_reg == SERVE_D) & mem_resp;
  assign i_resp  = i_done;
  assign d_resp  = d_done;
  assign i_rdata = i_done ? mem_rdata : i_rdata_reg;
  assign d_rdata = d_done ? mem_rdata : d_rdata_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      last_grant_d_reg <= 1'b0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mem_address      <= '0;
      mem_wdata        <= '0;
      i_rdata_reg      <= '0;
      d_rdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_i | req_d) begin
            state_reg        <= grant_d ? SERVE_D : SERVE_I;
            last_grant_d_reg <= grant_d;
            mem_address      <= grant_d ? d_address : i_address;
            mem_wdata        <= grant_d ? d_wdata : i_wdata;
            // A write wins over a simultaneous read from the same requester
            mem_write        <= grant_d ? d_write : i_write;
            mem_read         <= grant_d ? (d_read & ~d_write) : (i_read & ~i_write);
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            state_reg   <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            i_rdata_reg <= mem_rdata;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            state_reg   <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            d_rdata_reg <= mem_rdata;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  a_i_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(i_read && i_write));
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(d_read && d_write));

endmodule
